// File: rtl/ball_link_pkg.sv
// Shared types and constants for the ball-state I2C link: FSM states, register offsets, frame layout.
package ball_link_pkg;

  typedef enum logic [2:0] {IDLE, LATCH, START, BIT, ACK, STOP, DONE} state_t;

  localparam logic [3:0] REG_Y0   = 4'd0;
  localparam logic [3:0] REG_Y1   = 4'd1;
  localparam logic [3:0] REG_VY   = 4'd2;
  localparam logic [3:0] REG_GRAV = 4'd3;
  localparam logic [3:0] REG_FAST = 4'd4;
  localparam logic [3:0] REG_WIN  = 4'd5;

  localparam logic [3:0] FRAME_LEN   = 4'd8;
  localparam logic [1:0] RETRY_LIMIT = 2'd3;

  typedef struct packed {
    logic [9:0] y;
    logic [7:0] vy;
    logic [1:0] grav;
    logic       fast;
    logic       win;
  } ball_t;

  // Byte 0 is the write address, byte 1 the register pointer, bytes 2..7 the ball registers.
  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [6:0] addr,
                                            input ball_t b);
    logic [7:0] r;
    r = 8'h00;
    case (idx)
      4'd0: r = {addr, 1'b0};
      4'd1: r = {4'h0, REG_Y0};
      default: begin
        case (idx - 4'd2)
          REG_Y0:   r = {b.y[9:8], 6'b0};
          REG_Y1:   r = b.y[7:0];
          REG_VY:   r = b.vy;
          REG_GRAV: r = {6'b0, b.grav};
          REG_FAST: r = {7'b0, b.fast};
          REG_WIN:  r = {7'b0, b.win};
          default:  r = 8'h00;
        endcase
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/i2c_qtr_tick.sv
// Quarter-SCL-period timebase: one-cycle tick every QTR_DIV clocks while enabled.
// Disabling clears the count so each enable starts a full quarter.
module i2c_qtr_tick #(
  parameter int QTR_DIV = 62
) (
  input  logic clk_25MHZ,
  input  logic reset,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(QTR_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || cnt_q == LAST) cnt_d = '0;
    else                        cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/ball_link_i2c_tx.sv
// Single-master I2C writer pushing the 6-byte ball state to the peer board on a level trigger.
// Macro BALL_LINK_RETRY_EN: when defined, a NACK restarts the frame (up to 3 retries) before flagging nack_err.
module ball_link_i2c_tx
  import ball_link_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         QTR_DIV    = 62
) (
  input  logic       clk_25MHZ,
  input  logic       reset,
  input  logic       ball_send_trigger,
  input  logic [9:0] ball_y,
  input  logic [7:0] ball_vy,
  input  logic [1:0] gravity_counter,
  input  logic       fast_ball,
  input  logic       win_flag,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_in,
  output logic       is_i2c_master_done,
  output logic       busy,
  output logic       nack_err
);

  state_t     state_q;
  logic [2:0] phase_q;
  logic [3:0] byte_q;
  logic [2:0] bit_q;
  ball_t      cap_q;
  logic       ack_q, first_q;
  logic       scl_q, sda_oe_q, done_q, busy_q, nack_q;
`ifdef BALL_LINK_RETRY_EN
  logic [1:0] retry_q;
  logic       restart_q;
`endif

  logic       tick, qtr_en, ack_now;
  logic [7:0] cur_byte, next_byte;

  assign qtr_en = (state_q == START) || (state_q == BIT) || (state_q == ACK) || (state_q == STOP);

  i2c_qtr_tick #(.QTR_DIV(QTR_DIV)) u_qtr (
    .clk_25MHZ(clk_25MHZ),
    .reset    (reset),
    .en_i     (qtr_en),
    .tick_o   (tick)
  );

  assign cur_byte  = frame_byte(byte_q, SLAVE_ADDR, cap_q);
  assign next_byte = frame_byte(byte_q + 4'd1, SLAVE_ADDR, cap_q);
  // ACK is sampled on the first cycle of phase 3; bypass keeps it valid even when that cycle also ticks.
  assign ack_now   = (phase_q == 3'd3 && first_q) ? sda_in : ack_q;

  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= 3'd0;
      byte_q   <= 4'd0;
      bit_q    <= 3'd0;
      cap_q    <= '0;
      ack_q    <= 1'b0;
      first_q  <= 1'b0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      nack_q   <= 1'b0;
`ifdef BALL_LINK_RETRY_EN
      retry_q   <= 2'd0;
      restart_q <= 1'b0;
`endif
    end else begin
      first_q <= tick;
      case (state_q)
        IDLE: begin
          scl_q    <= 1'b1;
          sda_oe_q <= 1'b0;
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          if (ball_send_trigger) begin
            state_q <= LATCH;
            busy_q  <= 1'b1;
          end
        end
        LATCH: begin
          cap_q   <= {ball_y, ball_vy, gravity_counter, fast_ball, win_flag};
          nack_q  <= 1'b0;
          byte_q  <= 4'd0;
          bit_q   <= 3'd7;
          phase_q <= 3'd0;
`ifdef BALL_LINK_RETRY_EN
          retry_q   <= 2'd0;
          restart_q <= 1'b0;
`endif
          state_q <= START;
        end
        START: if (tick) begin
          if (phase_q == 3'd0) begin
            sda_oe_q <= 1'b1;
            phase_q  <= 3'd1;
          end else begin
            scl_q    <= 1'b0;
            sda_oe_q <= ~cur_byte[7];
            bit_q    <= 3'd7;
            phase_q  <= 3'd0;
            state_q  <= BIT;
          end
        end
        BIT: if (tick) begin
          phase_q <= phase_q + 3'd1;
          case (phase_q)
            3'd1: scl_q <= 1'b1;
            3'd3: begin
              scl_q   <= 1'b0;
              phase_q <= 3'd0;
              if (bit_q == 3'd0) begin
                sda_oe_q <= 1'b0;
                state_q  <= ACK;
              end else begin
                bit_q    <= bit_q - 3'd1;
                sda_oe_q <= ~cur_byte[bit_q - 3'd1];
              end
            end
            default: ;
          endcase
        end
        ACK: begin
          if (phase_q == 3'd3 && first_q) ack_q <= sda_in;
          if (tick) begin
            phase_q <= phase_q + 3'd1;
            case (phase_q)
              3'd1: scl_q <= 1'b1;
              3'd3: begin
                scl_q   <= 1'b0;
                phase_q <= 3'd0;
                if (!ack_now && byte_q != FRAME_LEN - 4'd1) begin
                  byte_q   <= byte_q + 4'd1;
                  bit_q    <= 3'd7;
                  sda_oe_q <= ~next_byte[7];
                  state_q  <= BIT;
                end else begin
                  sda_oe_q <= 1'b1;
                  state_q  <= STOP;
                  if (ack_now) begin
`ifdef BALL_LINK_RETRY_EN
                    if (retry_q == RETRY_LIMIT) nack_q <= 1'b1;
                    else begin
                      retry_q   <= retry_q + 2'd1;
                      restart_q <= 1'b1;
                    end
`else
                    nack_q <= 1'b1;
`endif
                  end
                end
              end
              default: ;
            endcase
          end
        end
        STOP: if (tick) begin
          phase_q <= phase_q + 3'd1;
          case (phase_q)
            3'd0: scl_q    <= 1'b1;
            3'd1: sda_oe_q <= 1'b0;
            3'd2: begin
`ifdef BALL_LINK_RETRY_EN
              if (!restart_q) begin
                phase_q <= 3'd0;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= DONE;
              end
`else
              phase_q <= 3'd0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= DONE;
`endif
            end
`ifdef BALL_LINK_RETRY_EN
            // Phases 3..6 are the idle gap before the retried START.
            3'd6: begin
              restart_q <= 1'b0;
              byte_q    <= 4'd0;
              bit_q     <= 3'd7;
              phase_q   <= 3'd0;
              state_q   <= START;
            end
`endif
            default: ;
          endcase
        end
        DONE: begin
          if (!ball_send_trigger) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign scl                = scl_q;
  assign sda_oe             = sda_oe_q;
  assign is_i2c_master_done = done_q;
  assign busy               = busy_q;
  assign nack_err           = nack_q;

endmodule

// File: tb/tb_ball_link_i2c_tx.sv
// Bench for ball_link_i2c_tx: bus monitor decodes bytes/START/STOP and pops a queue of expected bytes.
module tb_ball_link_i2c_tx;

  logic       clk_25MHZ = 1'b0;
  logic       reset, ball_send_trigger;
  logic [9:0] ball_y;
  logic [7:0] ball_vy;
  logic [1:0] gravity_counter;
  logic       fast_ball, win_flag;
  logic       scl, sda_oe, sda_in, is_i2c_master_done, busy, nack_err;

  logic       slave_pull;
  logic       ack_en;
  assign sda_in = ~sda_oe & ~slave_pull;

  always #5 clk_25MHZ = ~clk_25MHZ;

  ball_link_i2c_tx #(.SLAVE_ADDR(7'h42), .QTR_DIV(4)) dut (
    .clk_25MHZ         (clk_25MHZ),
    .reset             (reset),
    .ball_send_trigger (ball_send_trigger),
    .ball_y            (ball_y),
    .ball_vy           (ball_vy),
    .gravity_counter   (gravity_counter),
    .fast_ball         (fast_ball),
    .win_flag          (win_flag),
    .scl               (scl),
    .sda_oe            (sda_oe),
    .sda_in            (sda_in),
    .is_i2c_master_done(is_i2c_master_done),
    .busy              (busy),
    .nack_err          (nack_err)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int start_cnt = 0, stop_cnt = 0, byte_cnt = 0, frame_bytes = 0, bitcnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave-side bus monitor: wired-AND SDA view, ACKs when ack_en is set.
  initial begin : monitor
    logic       line, prev_scl, prev_sda;
    logic [7:0] shreg;
    logic [15:0] want;
    slave_pull = 1'b0;
    prev_scl = 1'b1;
    prev_sda = 1'b1;
    shreg = 8'h00;
    forever begin
      @(negedge clk_25MHZ);
      line = ~sda_oe & ~slave_pull;
      if (reset) begin
        bitcnt = 0;
        slave_pull = 1'b0;
      end else if (prev_scl && scl) begin
        if (prev_sda && !line) begin
          start_cnt++;
          bitcnt = 0;
          frame_bytes = 0;
        end else if (!prev_sda && line) begin
          stop_cnt++;
        end
      end else if (!prev_scl && scl) begin
        if (bitcnt < 8) shreg = {shreg[6:0], line};
        bitcnt++;
        if (bitcnt == 8) begin
          frame_bytes++;
          byte_cnt++;
          if (exp_q.size() > 0) want = {8'h00, exp_q.pop_front()};
          else                  want = 16'hFFFF;
          check_eq("rx_byte", {24'h0, shreg}, {16'h0, want});
        end
      end else if (prev_scl && !scl) begin
        if (bitcnt == 8) slave_pull = ack_en;
        else if (bitcnt == 9) begin
          slave_pull = 1'b0;
          bitcnt = 0;
        end
      end
      prev_scl = scl;
      prev_sda = ~sda_oe & ~slave_pull;
    end
  end

  task automatic drive_and_push(input logic [9:0] y, input logic [7:0] vy, input logic [1:0] g,
                                input logic f, input logic w);
    ball_y = y;
    ball_vy = vy;
    gravity_counter = g;
    fast_ball = f;
    win_flag = w;
    exp_q.push_back(8'h84);
    exp_q.push_back(8'h00);
    exp_q.push_back({y[9:8], 6'b0});
    exp_q.push_back(y[7:0]);
    exp_q.push_back(vy);
    exp_q.push_back({6'b0, g});
    exp_q.push_back({7'b0, f});
    exp_q.push_back({7'b0, w});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_25MHZ);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (is_i2c_master_done !== 1'b1 && n < 8000) begin
      tick(1);
      n++;
    end
    check_eq(tag, {31'h0, is_i2c_master_done}, 32'h1);
  endtask

  initial begin
    int s0, p0, b0, n, attempts;
`ifdef BALL_LINK_RETRY_EN
    attempts = 4;
`else
    attempts = 1;
`endif
    reset = 1'b1;
    ball_send_trigger = 1'b0;
    ack_en = 1'b1;
    ball_y = '0; ball_vy = '0; gravity_counter = '0; fast_ball = 1'b0; win_flag = 1'b0;
    tick(3);
    check_eq("rst_scl",  {31'h0, scl}, 32'h1);
    check_eq("rst_sda",  {31'h0, sda_oe}, 32'h0);
    check_eq("rst_done", {31'h0, is_i2c_master_done}, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_nack", {31'h0, nack_err}, 32'h0);
    reset = 1'b0;
    tick(2);

    // Normal frame, then trigger held 5000 cycles past done.
    drive_and_push(10'd300, -8'd3, 2'd2, 1'b1, 1'b0);
    s0 = start_cnt;
    ball_send_trigger = 1'b1;
    tick(3);
    check_eq("t1_busy", {31'h0, busy}, 32'h1);
    wait_done("t1_done");
    check_eq("t1_nack",   {31'h0, nack_err}, 32'h0);
    check_eq("t1_qempty", exp_q.size(), 32'h0);
    check_eq("t1_nbytes", frame_bytes, 32'd8);
    check_eq("t1_busy0",  {31'h0, busy}, 32'h0);
    n = 0;
    repeat (5000) begin
      tick(1);
      if (is_i2c_master_done !== 1'b1) n++;
    end
    check_eq("hs_done_held", n, 32'h0);
    ball_send_trigger = 1'b0;
    tick(1);
    check_eq("hs_done_fall", {31'h0, is_i2c_master_done}, 32'h0);
    tick(200);
    check_eq("hs_one_start", start_cnt - s0, 32'd1);
    check_eq("hs_idle_busy", {31'h0, busy}, 32'h0);

    // Inputs change mid-frame; captured copy must be transmitted.
    drive_and_push(10'd300, 8'd5, 2'd3, 1'b0, 1'b1);
    b0 = byte_cnt;
    ball_send_trigger = 1'b1;
    n = 0;
    while (byte_cnt < b0 + 1 && n < 4000) begin tick(1); n++; end
    ball_y = 10'd479;
    ball_vy = 8'h11;
    win_flag = 1'b0;
    wait_done("t2_done");
    check_eq("t2_qempty", exp_q.size(), 32'h0);
    ball_send_trigger = 1'b0;
    tick(2);

    // Slave never ACKs.
    ack_en = 1'b0;
    repeat (attempts) exp_q.push_back(8'h84);
    s0 = start_cnt; p0 = stop_cnt; b0 = byte_cnt;
    ball_send_trigger = 1'b1;
    wait_done("nack_done");
    check_eq("nack_err",    {31'h0, nack_err}, 32'h1);
    check_eq("nack_starts", start_cnt - s0, attempts);
    check_eq("nack_stops",  stop_cnt - p0, attempts);
    check_eq("nack_bytes",  byte_cnt - b0, attempts);
    check_eq("nack_qempty", exp_q.size(), 32'h0);
    ball_send_trigger = 1'b0;
    ack_en = 1'b1;
    tick(2);

    // Trigger dropped mid-frame: frame completes, done lasts one cycle, nack_err cleared.
    drive_and_push(10'h3FF, 8'h80, 2'd1, 1'b1, 1'b1);
    ball_send_trigger = 1'b1;
    tick(100);
    ball_send_trigger = 1'b0;
    wait_done("t4_done");
    check_eq("t4_nack", {31'h0, nack_err}, 32'h0);
    n = 0;
    while (is_i2c_master_done === 1'b1 && n < 10) begin tick(1); n++; end
    check_eq("t4_done_len", n, 32'd1);
    check_eq("t4_qempty", exp_q.size(), 32'h0);
    tick(2);

    // Reset in the middle of byte 3, then a fresh frame.
    drive_and_push(10'd300, -8'd3, 2'd2, 1'b1, 1'b0);
    ball_send_trigger = 1'b1;
    n = 0;
    while (!(frame_bytes == 3 && bitcnt == 4) && n < 4000) begin tick(1); n++; end
    check_eq("t5_reached", {31'h0, n < 4000}, 32'h1);
    reset = 1'b1;
    #1;
    check_eq("t5_scl",  {31'h0, scl}, 32'h1);
    check_eq("t5_sda",  {31'h0, sda_oe}, 32'h0);
    check_eq("t5_busy", {31'h0, busy}, 32'h0);
    exp_q.delete();
    ball_send_trigger = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    drive_and_push(10'd677, 8'h7F, 2'd1, 1'b0, 1'b1);
    ball_send_trigger = 1'b1;
    wait_done("t5_done");
    check_eq("t5_nack",   {31'h0, nack_err}, 32'h0);
    check_eq("t5_qempty", exp_q.size(), 32'h0);
    check_eq("t5_nbytes", frame_bytes, 32'd8);
    ball_send_trigger = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
